// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the async FIFO write port in the wclk domain.
// One requester holds the port per burst; a burst ends on req_last or after MAXBURST beats.
module fifo_wr_arbiter #(
   parameter int NREQ     = 4,
   parameter int DSIZE    = 8,
   parameter int MAXBURST = 8
) (
   input  logic                   wclk,
   input  logic                   wrst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        req_last,
   input  logic [NREQ*DSIZE-1:0]  req_data,
   output logic [NREQ-1:0]        req_ready,
   input  logic                   wfull,
   output logic                   winc,
   output logic [DSIZE-1:0]       wdata,
   output logic [NREQ-1:0]        gnt,
   output logic                   busy
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(MAXBURST) + 1;
   // Full-width compare so MAXBURST=256 releases on beat 255 instead of wrapping.
   localparam logic [CW-1:0] LAST_BEAT = CW'(MAXBURST - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state;
   logic [PW-1:0] rr_ptr;
   logic [CW-1:0] beat_cnt;

   logic [PW-1:0] g_idx;
   logic [PW-1:0] scan_idx;
   logic [PW-1:0] winner;
   logic          any_req;
   logic          release_burst;
   logic [PW-1:0] next_ptr;

   // NOTE: every always_comb output gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      g_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) g_idx = PW'(i);
      end
   end

   // Scan downward so the candidate closest to rr_ptr overwrites the others.
   always_comb begin
      any_req  = 1'b0;
      winner   = rr_ptr;
      scan_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan_idx = PW'((int'(rr_ptr) + k) % NREQ);
         if (req[scan_idx]) begin
            any_req = 1'b1;
            winner  = scan_idx;
         end
      end
   end

   assign req_ready     = wfull ? '0 : gnt;
   assign winc          = ~wfull & (|(req & gnt));
   assign wdata         = (|gnt) ? req_data[int'(g_idx)*DSIZE +: DSIZE] : '0;
   assign release_burst = winc & (req_last[g_idx] | (beat_cnt == LAST_BEAT));
   assign next_ptr      = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         busy     <= 1'b0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state    <= GRANT;
                  gnt      <= NREQ'(1) << winner;
                  busy     <= 1'b1;
                  beat_cnt <= '0;
               end
            end
            GRANT: begin
               if (winc) beat_cnt <= beat_cnt + CW'(1);
               if (release_burst) begin
                  state  <= IDLE;
                  gnt    <= '0;
                  busy   <= 1'b0;
                  rr_ptr <= next_ptr;
               end
            end
         endcase
      end
   end

endmodule
